i2c_target: RTL and testbench

I2C target (responder) that answers the existing I2C controller on the shared scl/sda bus and bridges transfers into a byte-wide register memory. Bus lines are oversampled on the system clock. The block decodes START/STOP, matches a 7-bit device address, and accepts a register-pointer byte. It then performs auto-incrementing writes into memory, or reads from memory with byte-by-byte controller ACK/NACK.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_sync.sv | 66 ++++++
 rtl/i2c_target.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target.
//   i2c_tgt_state_t  : target protocol state encoding
//   DEV_ADDR_DEFAULT : default 7-bit device address
//   ACK / NACK       : SDA levels of the acknowledge bit
//   majority3        : 2-of-3 vote used by the optional line glitch filter
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;
  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWr,
    StWrAck,
    StRd,
    StRdAck,
    StIgnore
  } i2c_tgt_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line conditioning for the I2C target.
// Each raw line passes a 2-flop synchronizer, then (when I2C_TARGET_GLITCH_FILTER_EN is
// defined) a registered 3-sample majority filter, then an edge-detect register.
//   clk        : system clock
//   scl_in     : raw SCL from the pad
//   sda_in     : raw SDA from the pad
//   scl_rise   : one-cycle pulse, conditioned SCL went 0 -> 1
//   scl_fall   : one-cycle pulse, conditioned SCL went 1 -> 0
//   start      : one-cycle pulse, SDA fell while SCL stayed high
//   stop       : one-cycle pulse, SDA rose while SCL stayed high
//   sda_level  : conditioned SDA level
// The line flops carry no reset on purpose: they keep tracking the bus while the target is
// held in reset, so releasing reset never manufactures a false edge or START.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_level
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_filt;
  logic       sda_filt;
  logic       scl_prev;
  logic       sda_prev;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[0], scl_in};
    sda_sync <= {sda_sync[0], sda_in};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  // A change must persist for two samples to win the vote, so 1-clk pulses vanish.
  always_ff @(posedge clk) begin
    scl_hist <= {scl_hist[0], scl_sync[1]};
    sda_hist <= {sda_hist[0], sda_sync[1]};
    scl_filt <= majority3(scl_sync[1], scl_hist[0], scl_hist[1]);
    sda_filt <= majority3(sda_sync[1], sda_hist[0], sda_hist[1]);
  end
`else
  assign scl_filt = scl_sync[1];
  assign sda_filt = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    scl_prev <= scl_filt;
    sda_prev <= sda_filt;
  end

  assign scl_rise  = scl_filt & ~scl_prev;
  assign scl_fall  = ~scl_filt & scl_prev;
  assign start     = scl_filt & scl_prev & sda_prev & ~sda_filt;
  assign stop      = scl_filt & scl_prev & ~sda_prev & sda_filt;
  assign sda_level = sda_filt;

endmodule

// File: rtl/i2c_target.sv
// I2C target bridging bus transfers into a byte-wide register memory.
// Protocol: [START] addr+R/W [ACK] then either pointer byte [ACK] + write bytes [ACK]...,
// or read bytes each followed by a controller ACK/NACK. The register pointer persists
// across transactions and auto-increments.
//   clk, reset     : system clock, synchronous active-high reset
//   scl_in, sda_in : raw bus levels
//   sda_drive_low  : 1 pulls SDA low (open drain)
//   mem_wr_en      : one-cycle write strobe with mem_addr / mem_wdata
//   mem_rd_en      : one-cycle read strobe with mem_addr; mem_rdata valid 1 clk later
//   busy           : set on address match, cleared by STOP or a non-matching address
// Build option: I2C_TARGET_GLITCH_FILTER_EN adds a majority filter on both lines.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 6,
  parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_drive_low,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_level;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (start_det),
    .stop      (stop_det),
    .sda_level (sda_level)
  );

  i2c_tgt_state_t       state_q;
  logic [3:0]           bit_cnt_q;
  logic [DATAWIDTH-2:0] shift_q;
  logic [DATAWIDTH-1:0] tx_q;
  logic [ADDRWIDTH-1:0] ptr_q;
  logic                 rw_q;
  logic                 ack_drv_q;      // ACK states: low phase of the ACK bit is underway
  logic                 cap_pending_q;  // mem_rdata is valid this cycle

  logic [DATAWIDTH-1:0] rx_byte;
  logic [ADDRWIDTH-1:0] ptr_inc;

  // Byte as it stands once the current rising-edge bit is shifted in.
  assign rx_byte = {shift_q, sda_level};
  assign ptr_inc = ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tx_q          <= '0;
      ptr_q         <= '0;
      rw_q          <= 1'b0;
      ack_drv_q     <= 1'b0;
      cap_pending_q <= 1'b0;
      sda_drive_low <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      mem_wr_en     <= 1'b0;
      mem_rd_en     <= 1'b0;
      cap_pending_q <= mem_rd_en;

      if (stop_det) begin
        state_q       <= StIdle;
        sda_drive_low <= 1'b0;
        ack_drv_q     <= 1'b0;
        busy          <= 1'b0;
      end else if (start_det) begin
        // busy is left alone here; the address byte decides it.
        state_q       <= StAddr;
        bit_cnt_q     <= '0;
        sda_drive_low <= 1'b0;
        ack_drv_q     <= 1'b0;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[DATAWIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (rx_byte[DATAWIDTH-1:1] == DEV_ADDR) begin
                  state_q <= StAddrAck;
                  rw_q    <= rx_byte[0];
                  busy    <= 1'b1;
                end else begin
                  state_q <= StIgnore;
                  busy    <= 1'b0;
                end
              end
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                ack_drv_q     <= 1'b1;
                sda_drive_low <= ~ACK;
                // Fetch now so the byte is in tx_q before the first data falling edge.
                if (rw_q) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= ptr_q;
                end
              end else begin
                ack_drv_q <= 1'b0;
                if (rw_q) begin
                  sda_drive_low <= ~tx_q[DATAWIDTH-1];
                  tx_q          <= {tx_q[DATAWIDTH-2:0], 1'b0};
                  bit_cnt_q     <= 4'd1;
                  state_q       <= StRd;
                end else begin
                  sda_drive_low <= 1'b0;
                  bit_cnt_q     <= '0;
                  state_q       <= StPtr;
                end
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[DATAWIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                ptr_q   <= rx_byte[ADDRWIDTH-1:0];
                state_q <= StPtrAck;
              end
            end
          end

          StPtrAck: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                ack_drv_q     <= 1'b1;
                sda_drive_low <= ~ACK;
              end else begin
                ack_drv_q     <= 1'b0;
                sda_drive_low <= 1'b0;
                bit_cnt_q     <= '0;
                state_q       <= StWr;
              end
            end
          end

          StWr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[DATAWIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                mem_wr_en <= 1'b1;
                mem_addr  <= ptr_q;
                mem_wdata <= rx_byte;
                state_q   <= StWrAck;
              end
            end
          end

          StWrAck: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                ack_drv_q     <= 1'b1;
                sda_drive_low <= ~ACK;
              end else begin
                ack_drv_q     <= 1'b0;
                sda_drive_low <= 1'b0;
                ptr_q         <= ptr_inc;
                bit_cnt_q     <= '0;
                state_q       <= StWr;
              end
            end
          end

          StRd: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_drive_low <= 1'b0;
                state_q       <= StRdAck;
              end else begin
                sda_drive_low <= ~tx_q[DATAWIDTH-1];
                tx_q          <= {tx_q[DATAWIDTH-2:0], 1'b0};
                bit_cnt_q     <= bit_cnt_q + 4'd1;
              end
            end
          end

          StRdAck: begin
            if (scl_rise) begin
              if (sda_level == NACK) begin
                state_q <= StIgnore;
              end else begin
                ptr_q     <= ptr_inc;
                mem_rd_en <= 1'b1;
                mem_addr  <= ptr_inc;
                bit_cnt_q <= '0;
                state_q   <= StRd;
              end
            end
          end

          default: ;
        endcase
      end

      if (cap_pending_q) begin
        tx_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_drive_low;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  // Open-drain wired-AND of controller and target.
  wire sda_bus = sda_ctrl & ~sda_drive_low;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk           (clk),
    .reset         (reset),
    .scl_in        (scl_ctrl),
    .sda_in        (sda_bus),
    .sda_drive_low (sda_drive_low),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  // Register memory behind the target.
  logic [7:0] mem_model [64];
  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
  end

  // Bus/strobe monitor.
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          drive_cnt = 0;
  int          busy_cnt = 0;
  int          both_cnt = 0;
  logic [13:0] wr_obs[$];
  logic [5:0]  rd_obs[$];
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_cnt++;
      wr_obs.push_back({mem_addr, mem_wdata});
    end
    if (mem_rd_en) begin
      rd_cnt++;
      rd_obs.push_back(mem_addr);
    end
    if (mem_wr_en && mem_rd_en) both_cnt++;
    if (sda_drive_low) drive_cnt++;
    if (busy) busy_cnt++;
  end

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  int          wr_idx = 0;
  int          rd_idx = 0;
  logic [13:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b1; tick(5);
    scl_ctrl = 1'b1; tick(10);
    sda_ctrl = 1'b0; tick(10);
    scl_ctrl = 1'b0; tick(5);
  endtask

  task automatic bus_stop();
    sda_ctrl = 1'b0; tick(5);
    scl_ctrl = 1'b1; tick(10);
    sda_ctrl = 1'b1; tick(10);
  endtask

  task automatic send_bit(input logic b, output logic r);
    sda_ctrl = b;    tick(5);
    scl_ctrl = 1'b1; tick(5);
    r = sda_bus;     tick(5);
    scl_ctrl = 1'b0; tick(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      b = {b[6:0], r};
    end
    send_bit(ack, r);
  endtask

  task automatic drain_writes(input string tag);
    logic [13:0] e;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (wr_idx < wr_obs.size()) begin
        check(tag, wr_obs[wr_idx], e);
        wr_idx++;
      end else begin
        check({tag, "_missing"}, wr_obs.size(), wr_idx + 1);
      end
    end
    check({tag, "_extra"}, wr_obs.size(), wr_idx);
  endtask

  task automatic expect_rd_addr(input string tag, input logic [5:0] a);
    if (rd_idx < rd_obs.size()) begin
      check(tag, rd_obs[rd_idx], a);
      rd_idx++;
    end else begin
      check({tag, "_missing"}, rd_obs.size(), rd_idx + 1);
    end
  endtask

  task automatic read_check(input string tag, input logic ack);
    logic [7:0] got;
    read_byte(ack, got);
    check(tag, got, exp_rd.pop_front());
  endtask

  initial begin
    logic       ack;
    logic       r;
    int         snap_wr;
    int         snap_rd;
    int         snap_drv;
    int         snap_busy;
    logic [7:0] partial;
    logic       glitch_busy_exp;

    // Reset state.
    tick(8);
    reset = 1'b0;
    tick(2);
    check("rst_sda_drive", sda_drive_low, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 6'h00);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);

    // Write ptr 0x05, data 0x3C, 0x7E.
    bus_start();
    write_byte(8'hA0, ack); check("t1_ack_addr", ack, 1'b0);
    check("t1_busy", busy, 1'b1);
    write_byte(8'h05, ack); check("t1_ack_ptr", ack, 1'b0);
    exp_wr.push_back({6'h05, 8'h3C});
    write_byte(8'h3C, ack); check("t1_ack_d0", ack, 1'b0);
    exp_wr.push_back({6'h06, 8'h7E});
    write_byte(8'h7E, ack); check("t1_ack_d1", ack, 1'b0);
    bus_stop();
    tick(5);
    check("t1_busy_after_stop", busy, 1'b0);
    drain_writes("t1_wr");

    // Pointer wrap.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h3F, ack);
    exp_wr.push_back({6'h3F, 8'h11});
    write_byte(8'h11, ack);
    exp_wr.push_back({6'h00, 8'h22});
    write_byte(8'h22, ack); check("t2_ack_wrap", ack, 1'b0);
    bus_stop();
    drain_writes("t2_wr");

    // Preload [0x10]=0x55, [0x11]=0xAA, then read back via repeated START.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    exp_wr.push_back({6'h10, 8'h55});
    write_byte(8'h55, ack);
    exp_wr.push_back({6'h11, 8'hAA});
    write_byte(8'hAA, ack);
    bus_stop();
    drain_writes("t3_preload");

    snap_rd = rd_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    bus_start();
    write_byte(8'hA1, ack); check("t3_ack_rd_addr", ack, 1'b0);
    exp_rd.push_back(8'h55);
    read_check("t3_rd0", 1'b0);
    exp_rd.push_back(8'hAA);
    read_check("t3_rd1", 1'b1);
    check("t3_released_after_nack", sda_drive_low, 1'b0);
    bus_stop();
    tick(5);
    check("t3_rd_count", rd_cnt - snap_rd, 2);
    expect_rd_addr("t3_rd_addr0", 6'h10);
    expect_rd_addr("t3_rd_addr1", 6'h11);
    check("t3_busy_after_stop", busy, 1'b0);

    // Read without pointer write continues from the retained pointer.
    bus_start();
    write_byte(8'hA1, ack);
    exp_rd.push_back(8'hAA);
    read_check("t3b_rd_cont", 1'b1);
    bus_stop();
    expect_rd_addr("t3b_rd_addr", 6'h11);

    // Non-matching address.
    snap_wr = wr_cnt; snap_rd = rd_cnt; snap_drv = drive_cnt; snap_busy = busy_cnt;
    bus_start();
    write_byte(8'hA4, ack); check("t4_nack_addr", ack, 1'b1);
    write_byte(8'h12, ack);
    bus_stop();
    tick(5);
    check("t4_no_drive", drive_cnt - snap_drv, 0);
    check("t4_no_wr", wr_cnt - snap_wr, 0);
    check("t4_no_rd", rd_cnt - snap_rd, 0);
    check("t4_busy_never", busy_cnt - snap_busy, 0);

    // Reset during the 4th data bit of a write.
    snap_wr = wr_cnt;
    partial = 8'h99;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    for (int i = 7; i >= 5; i--) send_bit(partial[i], r);
    sda_ctrl = partial[4]; tick(5);
    scl_ctrl = 1'b1; tick(2);
    reset = 1'b1; tick(3);
    reset = 1'b0; tick(1);
    check("t5_rst_sda_drive", sda_drive_low, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_addr", mem_addr, 6'h00);
    check("t5_rst_wdata", mem_wdata, 8'h00);
    tick(4);
    scl_ctrl = 1'b0; tick(5);
    for (int i = 3; i >= 0; i--) send_bit(partial[i], r);
    send_bit(1'b1, ack);
    check("t5_no_ack_after_rst", ack, 1'b1);
    bus_stop();
    check("t5_no_wr", wr_cnt - snap_wr, 0);

    // Pointer is back at 0 after reset.
    bus_start();
    write_byte(8'hA1, ack); check("t5_ack_rd", ack, 1'b0);
    exp_rd.push_back(8'h22);
    read_check("t5_rd_ptr0", 1'b1);
    bus_stop();
    expect_rd_addr("t5_rd_addr", 6'h00);

    // Full write after the aborted one.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    exp_wr.push_back({6'h20, 8'h99});
    write_byte(8'h99, ack); check("t5_ack_full", ack, 1'b0);
    bus_stop();
    drain_writes("t5_wr");

    // 1-clk SDA low glitch while SCL is high, inside a matched transfer.
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    glitch_busy_exp = 1'b1;
`else
    glitch_busy_exp = 1'b0;
`endif
    bus_start();
    write_byte(8'hA0, ack);
    sda_ctrl = 1'b1; tick(5);
    scl_ctrl = 1'b1; tick(5);
    sda_ctrl = 1'b0; tick(1);
    sda_ctrl = 1'b1; tick(8);
    check("t6_glitch_busy", busy, glitch_busy_exp);
    scl_ctrl = 1'b0; tick(5);
    bus_stop();
    tick(5);
    check("t6_busy_after_stop", busy, 1'b0);

    check("never_wr_and_rd", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
